apb_axil_bridge: RTL and testbench

- Parametrised APB4 slave to AXI4-Lite master bridge; one outstanding transfer at a time.
- Sits between the APB peripheral bus and the AXI4-Lite interconnect.
- Adds features the first-generation APB port lacks:
  - configurable data and address widths
  - write strobes passed through to AXI
  - AXI response mapped to pslverr
  - a timeout watchdog that completes a stalled APB access with an error.

---
 rtl/apb_axil_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_apb_axil_bridge.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_axil_bridge.sv
// APB4 slave to AXI4-Lite master bridge, one outstanding transfer at a time.
// Stalled AXI accesses are completed on APB with an error by a watchdog.
module apb_axil_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    abandon;
  logic [CNT_WIDTH-1:0]    wd_cnt;

  logic in_axi;
  logic completing;
  logic timeout_hit;
  logic aw_done;
  logic w_done;
  logic unused_inputs;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awprot  = prot_q;
  assign arprot  = prot_q;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;

  // Launch ignores penable and only the high response bit signals an error.
  assign unused_inputs = ^{penable, bresp[0], rresp[0]};

  assign in_axi     = (state == WR_REQ) || (state == WR_RESP) ||
                      (state == RD_REQ) || (state == RD_DATA);
  assign completing = ((state == WR_RESP) && bvalid) || ((state == RD_DATA) && rvalid);

  // A completing handshake on the limit cycle takes priority over the watchdog.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_axi && !abandon && !completing &&
                       (int'(wd_cnt) == TIMEOUT_CYCLES - 1);

  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      addr_q  <= '0;
      prot_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      abandon <= 1'b0;
      wd_cnt  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;

      if (in_axi && !abandon) begin
        wd_cnt <= wd_cnt + CNT_WIDTH'(1);
      end

      // Abandoned transfers keep their AXI valids up until the slave answers.
      if (timeout_hit) begin
        pready  <= 1'b1;
        pslverr <= 1'b1;
        prdata  <= '0;
        abandon <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (psel) begin
            addr_q  <= paddr;
            prot_q  <= pprot;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            wd_cnt  <= '0;
            if (pwrite) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (abandon) begin
              abandon <= 1'b0;
              state   <= IDLE;
            end else begin
              pready  <= 1'b1;
              pslverr <= bresp[1];
              state   <= DONE;
            end
          end
        end

        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (abandon) begin
              abandon <= 1'b0;
              state   <= IDLE;
            end else begin
              pready  <= 1'b1;
              pslverr <= rresp[1];
              prdata  <= rresp[1] ? '0 : rdata;
              state   <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_axil_bridge.sv
// Scoreboard bench for apb_axil_bridge: directed APB transfers against a
// configurable AXI4-Lite slave model, checked by an independent pready monitor.
module tb_apb_axil_bridge;

  logic        pclk;
  logic        preset;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          err;
    bit          chk_data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   setup_cyc = 0;
  int   aw_delay = 0, w_delay = 0, ar_delay = 0;
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit   b_hold = 0;
  bit   abort = 0;
  logic [1:0] bresp_cfg = 2'b00;

  apb_axil_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .paddr  (paddr),
    .pprot  (pprot),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr),
    .awaddr (awaddr),
    .awprot (awprot),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arprot (arprot),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI slave model: readies after a per-channel delay, responses when ready.
  always @(negedge pclk) begin
    if (awvalid) begin
      awready = (aw_cnt >= aw_delay);
      aw_cnt++;
    end else begin
      awready = 1'b0;
      aw_cnt  = 0;
    end
    if (wvalid) begin
      wready = (w_cnt >= w_delay);
      w_cnt++;
    end else begin
      wready = 1'b0;
      w_cnt  = 0;
    end
    if (arvalid) begin
      arready = (ar_cnt >= ar_delay);
      ar_cnt++;
    end else begin
      arready = 1'b0;
      ar_cnt  = 0;
    end
    bvalid = bready && !b_hold;
    bresp  = bresp_cfg;
    if (rready && rq_data.size() > 0) begin
      rvalid = 1'b1;
      rdata  = rq_data[0];
      rresp  = rq_resp[0];
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = '0;
    end
  end

  always @(posedge pclk) begin
    cyc++;
    if (rvalid && rready && !preset) begin
      void'(rq_data.pop_front());
      void'(rq_resp.pop_front());
    end
  end

  // Monitor: every pready pulse must match the oldest expected completion.
  always @(negedge pclk) begin
    if (!preset && pready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_pready: got pready=1, expected no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_pslverr"}, 64'(pslverr), 64'(e.err));
        checkOutput({e.name, "_apb_phase"}, 64'({psel, penable}), 64'(2'b11));
        if (e.chk_data) checkOutput({e.name, "_prdata"}, 64'(prdata), 64'(e.data));
        if (e.lat >= 0) checkOutput({e.name, "_latency"}, 64'(cyc - setup_cyc), 64'(e.lat));
      end
    end
  end

  task automatic applyStimulus(input string name, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input bit push,
                               input logic [31:0] exp_data, input bit exp_err, input bit chk_data,
                               input int exp_lat);
    int  n;
    bit  done;
    @(posedge pclk);
    #1;
    psel      = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = data;
    pstrb     = strb;
    pprot     = 3'b010;
    setup_cyc = cyc;
    if (push) sb.push_back('{name: name, data: exp_data, err: exp_err, chk_data: chk_data, lat: exp_lat});
    @(posedge pclk);
    #1;
    penable = 1'b1;
    n    = 0;
    done = 0;
    while (!done) begin
      @(negedge pclk);
      if (pready || abort) begin
        done = 1;
      end else if (++n > 100) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s_no_pready: got no pready in 100 cycles, expected completion", name);
        done = 1;
      end
    end
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wait_tk(input int k);
    @(posedge psel);
    repeat (k + 1) @(negedge pclk);
  endtask

  initial begin
    preset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    bresp   = '0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = '0;
    repeat (3) @(negedge pclk);
    checkOutput("reset_ctrl", 64'({pready, pslverr, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    checkOutput("reset_prdata", 64'(prdata), 64'd0);
    preset = 1'b0;

    // Write with immediate slave
    fork
      applyStimulus("t1_write", 1, 32'h40, 32'hA5A5_0003, 4'b0011, 1, 32'h0, 0, 0, 3);
      begin
        wait_tk(1);
        checkOutput("t1_awaddr", 64'(awaddr), 64'h40);
        checkOutput("t1_wstrb", 64'(wstrb), 64'h3);
        checkOutput("t1_wdata", 64'(wdata), 64'hA5A5_0003);
        checkOutput("t1_valids", 64'({awvalid, wvalid}), 64'(2'b11));
      end
    join

    // Read with arready delayed three cycles
    ar_delay = 3;
    rq_data.push_back(32'hDEAD_BEEF);
    rq_resp.push_back(2'b00);
    fork
      applyStimulus("t2_read", 0, 32'h80, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 0, 1, 6);
      begin
        wait_tk(1);
        checkOutput("t2_araddr", 64'(araddr), 64'h80);
        for (int i = 1; i <= 5; i++) begin
          checkOutput($sformatf("t2_arvalid_T%0d", i), 64'(arvalid), 64'(i <= 4));
          @(negedge pclk);
        end
        @(negedge pclk);
        checkOutput("t2_pready_one_cycle", 64'(pready), 64'd0);
      end
    join
    ar_delay = 0;

    // Write with split address and data handshakes
    w_delay = 3;
    fork
      applyStimulus("t3_write", 1, 32'h44, 32'h1234_5678, 4'hF, 1, 32'h0, 0, 0, 6);
      begin
        wait_tk(1);
        checkOutput("t3_T1_valids", 64'({awvalid, wvalid}), 64'(2'b11));
        @(negedge pclk);
        checkOutput("t3_T2_valids", 64'({awvalid, wvalid}), 64'(2'b01));
        repeat (2) @(negedge pclk);
        checkOutput("t3_T4_wvalid_bready", 64'({wvalid, bready}), 64'(2'b10));
        @(negedge pclk);
        checkOutput("t3_T5_wvalid_bready", 64'({wvalid, bready}), 64'(2'b01));
      end
    join
    w_delay = 0;

    // Response code mapping
    rq_data.push_back(32'h1234_5678);
    rq_resp.push_back(2'b11);
    applyStimulus("t4_read_decerr", 0, 32'h88, 32'h0, 4'h0, 1, 32'h0, 1, 1, 3);
    rq_data.push_back(32'hCAFE_0001);
    rq_resp.push_back(2'b01);
    applyStimulus("t4_read_exokay", 0, 32'h8C, 32'h0, 4'h0, 1, 32'hCAFE_0001, 0, 1, 3);
    bresp_cfg = 2'b10;
    applyStimulus("t4_write_slverr", 1, 32'h48, 32'h0, 4'hF, 1, 32'h0, 1, 0, 3);
    bresp_cfg = 2'b01;
    applyStimulus("t4_write_exokay", 1, 32'h4C, 32'h0, 4'hF, 1, 32'h0, 0, 0, 3);
    bresp_cfg = 2'b00;

    // Watchdog timeout, then a second read queued behind the abandoned one
    ar_delay = 1000;
    rq_data.push_back(32'h1111_1111);
    rq_resp.push_back(2'b00);
    rq_data.push_back(32'h600D_F00D);
    rq_resp.push_back(2'b00);
    applyStimulus("t5_timeout", 0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 1, 1, 9);
    checkOutput("t5_arvalid_kept", 64'(arvalid), 64'd1);
    fork
      applyStimulus("t5_second", 0, 32'h104, 32'h0, 4'h0, 1, 32'h600D_F00D, 0, 1, -1);
      begin
        repeat (6) @(negedge pclk);
        checkOutput("t5_stalled_pready", 64'(pready), 64'd0);
        checkOutput("t5_stalled_araddr", 64'(araddr), 64'h100);
        ar_delay = 0;
      end
    join

    // Reset while waiting for the write response
    b_hold = 1;
    fork
      applyStimulus("t6_reset", 1, 32'h200, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 0, 0, -1);
      begin
        wait_tk(2);
        checkOutput("t6_wr_resp_bready", 64'(bready), 64'd1);
        preset = 1'b1;
        abort  = 1;
        @(negedge pclk);
        checkOutput("t6_ctrl_zero", 64'({pready, pslverr, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        checkOutput("t6_prdata_zero", 64'(prdata), 64'd0);
        checkOutput("t6_addr_data_zero", {awaddr, wdata}, 64'd0);
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        abort  = 0;
        b_hold = 0;
      end
    join
    fork
      applyStimulus("t6_after_reset", 1, 32'h204, 32'h0BAD_CAFE, 4'b1100, 1, 32'h0, 0, 0, 3);
      begin
        wait_tk(1);
        checkOutput("t6_after_awaddr", 64'(awaddr), 64'h204);
        checkOutput("t6_after_wstrb", 64'(wstrb), 64'hC);
      end
    join

    repeat (5) @(negedge pclk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
